// File: rtl/rvfi_monitor.sv
// RVFI retirement-stream checker: order/PC continuity, x0 writes and a shadow
// register file. Define RVFI_MON_MEM_CHECK_EN to add the memory mask/alignment checks.
module rvfi_monitor #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [31:0] rvfi_rs2_rdata,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [31:0] rvfi_mem_rdata,
  input  logic [31:0] rvfi_mem_wdata,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  output logic [31:0] retired_count,
  output logic        error,
  output logic [3:0]  error_code,
  output logic [63:0] error_order,
  output logic [31:0] error_pc,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  state_e      state_r;
  state_e      state_next_s;
  logic [31:0] count_r;
  logic        error_r;
  logic [3:0]  error_code_r;
  logic [63:0] error_order_r;
  logic [31:0] error_pc_r;
  logic [63:0] prev_order_r;
  logic [31:0] prev_pc_r;
  logic [31:0] shadow_r [32];
  logic [31:0] shadow_valid_r;

  logic        check_en_s;
  logic [63:0] exp_order_s;
  logic [31:0] exp_pc_s;
  logic        rs1_bad_s;
  logic        rs2_bad_s;
  logic [3:0]  mem_code_s;
  logic [3:0]  code_s;
  logic        unused_s;

  function automatic logic mask_legal(input logic [3:0] mask);
    return (mask == 4'd0) || (mask == 4'd1) || (mask == 4'd3) || (mask == 4'd15);
  endfunction

  assign check_en_s  = rvfi_valid && (state_r != ST_FAIL);
  assign exp_order_s = (state_r == ST_IDLE) ? 64'd1 : (prev_order_r + 64'd1);
  assign exp_pc_s    = (state_r == ST_IDLE) ? RESET_PC : prev_pc_r;

  // Shadow reads see the value committed before this retirement.
  assign rs1_bad_s = (rvfi_rs1_addr != 5'd0) && shadow_valid_r[rvfi_rs1_addr] &&
                     (rvfi_rs1_rdata != shadow_r[rvfi_rs1_addr]);
  assign rs2_bad_s = (rvfi_rs2_addr != 5'd0) && shadow_valid_r[rvfi_rs2_addr] &&
                     (rvfi_rs2_rdata != shadow_r[rvfi_rs2_addr]);

`ifdef RVFI_MON_MEM_CHECK_EN
  // Memory mask legality, then alignment of the single active access.
  always_comb begin
    logic [3:0] mask_s;
    mem_code_s = 4'd0;
    mask_s     = rvfi_mem_rmask | rvfi_mem_wmask;
    if (((rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0)) ||
        !mask_legal(rvfi_mem_rmask) || !mask_legal(rvfi_mem_wmask)) begin
      mem_code_s = 4'd6;
    end else if (((mask_s == 4'd3) && (rvfi_mem_addr[0] != 1'b0)) ||
                 ((mask_s == 4'd15) && (rvfi_mem_addr[1:0] != 2'd0))) begin
      mem_code_s = 4'd7;
    end else begin
      mem_code_s = 4'd0;
    end
  end
  assign unused_s = ^{rvfi_insn, rvfi_mem_addr[31:2], rvfi_mem_rdata, rvfi_mem_wdata};
`else
  assign mem_code_s = 4'd0;
  assign unused_s   = ^{rvfi_insn, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
                        rvfi_mem_rmask, rvfi_mem_wmask, mask_legal(4'd0)};
`endif

  // Priority-ordered violation cause; zero means the retirement passes.
  always_comb begin
    code_s = 4'd0;
    if (rvfi_order != exp_order_s) begin
      code_s = 4'd1;
    end else if (rvfi_pc_rdata != exp_pc_s) begin
      code_s = 4'd2;
    end else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0)) begin
      code_s = 4'd3;
    end else if (rs1_bad_s) begin
      code_s = 4'd4;
    end else if (rs2_bad_s) begin
      code_s = 4'd5;
    end else begin
      code_s = mem_code_s;
    end
  end

  // Next-state logic; FAIL only leaves through reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (check_en_s) begin
          state_next_s = (code_s != 4'd0) ? ST_FAIL : ST_RUN;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_FAIL: state_next_s = ST_FAIL;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Counters, error capture, continuity tracking and shadow valid bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r        <= 32'd0;
      error_r        <= 1'b0;
      error_code_r   <= 4'd0;
      error_order_r  <= 64'd0;
      error_pc_r     <= 32'd0;
      prev_order_r   <= 64'd0;
      prev_pc_r      <= 32'd0;
      shadow_valid_r <= 32'd0;
    end else if (check_en_s) begin
      if (code_s != 4'd0) begin
        error_r       <= 1'b1;
        error_code_r  <= code_s;
        error_order_r <= rvfi_order;
        error_pc_r    <= rvfi_pc_rdata;
      end else begin
        count_r      <= count_r + 32'd1;
        prev_order_r <= rvfi_order;
        prev_pc_r    <= rvfi_pc_wdata;
        if (rvfi_rd_addr != 5'd0) begin
          shadow_valid_r[rvfi_rd_addr] <= 1'b1;
        end
      end
    end
  end

  // Shadow data needs no reset; the valid bits gate every read.
  always_ff @(posedge clock) begin
    if (check_en_s && (code_s == 4'd0) && (rvfi_rd_addr != 5'd0)) begin
      shadow_r[rvfi_rd_addr] <= rvfi_rd_wdata;
    end
  end

  assign retired_count = count_r;
  assign error         = error_r;
  assign error_code    = error_code_r;
  assign error_order   = error_order_r;
  assign error_pc      = error_pc_r;
  assign state         = state_r;

endmodule

// File: tb/tb_rvfi_monitor.sv
// Self-checking bench for rvfi_monitor: directed scenarios plus randomized
// retirement streams compared against a behavioural model of the checking rules.
module tb_rvfi_monitor;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rvfi_valid = 1'b0;
  logic [63:0] rvfi_order = 64'd0;
  logic [31:0] rvfi_insn = 32'd0, rvfi_pc_rdata = 32'd0, rvfi_pc_wdata = 32'd0;
  logic [4:0]  rvfi_rs1_addr = 5'd0, rvfi_rs2_addr = 5'd0, rvfi_rd_addr = 5'd0;
  logic [31:0] rvfi_rs1_rdata = 32'd0, rvfi_rs2_rdata = 32'd0, rvfi_rd_wdata = 32'd0;
  logic [31:0] rvfi_mem_addr = 32'd0, rvfi_mem_rdata = 32'd0, rvfi_mem_wdata = 32'd0;
  logic [3:0]  rvfi_mem_rmask = 4'd0, rvfi_mem_wmask = 4'd0;
  logic [31:0] retired_count;
  logic        error;
  logic [3:0]  error_code;
  logic [63:0] error_order;
  logic [31:0] error_pc;
  logic [1:0]  state;

  int n_pass = 0;
  int n_total = 0;

  rvfi_monitor #(.RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .retired_count(retired_count), .error(error), .error_code(error_code),
    .error_order(error_order), .error_pc(error_pc), .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  int          m_state;         // 0 idle, 1 run, 2 fail
  logic [63:0] m_last_order;
  logic [31:0] m_next_pc;
  logic [31:0] m_count;
  logic        m_err;
  logic [3:0]  m_code;
  logic [63:0] m_eorder;
  logic [31:0] m_epc;
  logic [31:0] m_regs [32];
  bit          m_known [32];

  function automatic bit legal_mask(input logic [3:0] m);
    return (m == 4'd0) || (m == 4'd1) || (m == 4'd3) || (m == 4'd15);
  endfunction

  function automatic logic [3:0] judge();
    logic [63:0] want_order;
    logic [31:0] want_pc;
    logic [3:0]  m;
    want_order = (m_state == 0) ? 64'd1 : m_last_order + 64'd1;
    want_pc    = (m_state == 0) ? RPC : m_next_pc;
    if (rvfi_order != want_order) return 4'd1;
    if (rvfi_pc_rdata != want_pc) return 4'd2;
    if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != 32'd0) return 4'd3;
    if (rvfi_rs1_addr != 5'd0 && m_known[rvfi_rs1_addr] && rvfi_rs1_rdata != m_regs[rvfi_rs1_addr]) return 4'd4;
    if (rvfi_rs2_addr != 5'd0 && m_known[rvfi_rs2_addr] && rvfi_rs2_rdata != m_regs[rvfi_rs2_addr]) return 4'd5;
`ifdef RVFI_MON_MEM_CHECK_EN
    if ((rvfi_mem_rmask != 4'd0 && rvfi_mem_wmask != 4'd0) ||
        !legal_mask(rvfi_mem_rmask) || !legal_mask(rvfi_mem_wmask)) return 4'd6;
    m = rvfi_mem_rmask | rvfi_mem_wmask;
    if (m == 4'd3 && rvfi_mem_addr % 2 != 0) return 4'd7;
    if (m == 4'd15 && rvfi_mem_addr % 4 != 0) return 4'd7;
`else
    m = 4'd0;
`endif
    return 4'd0;
  endfunction

  task automatic model_edge();
    logic [3:0] c;
    if (reset) begin
      m_state = 0; m_count = 32'd0; m_err = 1'b0; m_code = 4'd0;
      m_eorder = 64'd0; m_epc = 32'd0;
      for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
    end else if (m_state != 2 && rvfi_valid) begin
      c = judge();
      if (c != 4'd0) begin
        m_state = 2; m_err = 1'b1; m_code = c; m_eorder = rvfi_order; m_epc = rvfi_pc_rdata;
      end else begin
        m_state = 1; m_count = m_count + 32'd1;
        m_last_order = rvfi_order; m_next_pc = rvfi_pc_wdata;
        if (rvfi_rd_addr != 5'd0) begin
          m_regs[rvfi_rd_addr] = rvfi_rd_wdata;
          m_known[rvfi_rd_addr] = 1'b1;
        end
      end
    end
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs read 1 time unit later.
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [63:0] ord, input logic [31:0] pc, input logic [31:0] pcw,
                      input logic [4:0] rs1, input logic [31:0] rs1d,
                      input logic [4:0] rs2, input logic [31:0] rs2d,
                      input logic [4:0] rd, input logic [31:0] rdw);
    rvfi_valid = 1'b1; rvfi_order = ord; rvfi_pc_rdata = pc; rvfi_pc_wdata = pcw;
    rvfi_insn = $urandom;
    rvfi_rs1_addr = rs1; rvfi_rs1_rdata = rs1d; rvfi_rs2_addr = rs2; rvfi_rs2_rdata = rs2d;
    rvfi_rd_addr = rd; rvfi_rd_wdata = rdw;
    rvfi_mem_addr = 32'd0; rvfi_mem_rmask = 4'd0; rvfi_mem_wmask = 4'd0;
    rvfi_mem_rdata = $urandom; rvfi_mem_wdata = $urandom;
  endtask

  task automatic do_reset();
    rvfi_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    load(64'd5, 32'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd1);
    tick();                       // garbage before reset
    do_reset();
    n_total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
    n_total++; if (retired_count !== 32'd0) $display("FAIL reset_count: got %0d expected 0", retired_count); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL reset_error: got %0b expected 0", error); else n_pass++;
    n_total++; if ({error_code, error_order, error_pc} !== 100'd0)
      $display("FAIL reset_err_fields: got code %0d order %0h pc %h expected all 0", error_code, error_order, error_pc);
    else n_pass++;
  endtask

  task automatic test_sequence();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load(64'(i + 1), RPC + 32'(4 * i), RPC + 32'(4 * i + 4), 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'(i));
      tick();
    end
    rvfi_valid = 1'b0;
    tick();
    n_total++; if (retired_count !== 32'd3) $display("FAIL seq_count: got %0d expected 3", retired_count); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL seq_error: got %0b expected 0", error); else n_pass++;
    n_total++; if (state !== 2'd1) $display("FAIL seq_state: got %0d expected 1", state); else n_pass++;
  endtask

  task automatic test_order_error();
    do_reset();
    load(64'd2, RPC, RPC + 32'd4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    rvfi_valid = 1'b0;
    n_total++; if (error !== 1'b1 || error_code !== 4'd1)
      $display("FAIL order_code: got err %0b code %0d expected err 1 code 1", error, error_code); else n_pass++;
    n_total++; if (error_order !== 64'd2) $display("FAIL order_eorder: got %0d expected 2", error_order); else n_pass++;
    n_total++; if (retired_count !== 32'd0 || state !== 2'd2)
      $display("FAIL order_state: got count %0d state %0d expected 0 and 2", retired_count, state); else n_pass++;
  endtask

  task automatic test_shadow();
    do_reset();
    load(64'd1, RPC, RPC + 32'd4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'h1234);
    tick();
    load(64'd2, RPC + 32'd4, RPC + 32'd8, 5'd5, 32'h1235, 5'd0, 32'd0, 5'd6, 32'd7);
    tick();
    rvfi_valid = 1'b0;
    n_total++; if (error_code !== 4'd4) $display("FAIL shadow_code: got %0d expected 4", error_code); else n_pass++;
    n_total++; if (error_pc !== RPC + 32'd4) $display("FAIL shadow_pc: got %h expected %h", error_pc, RPC + 32'd4); else n_pass++;
    n_total++; if (retired_count !== 32'd1) $display("FAIL shadow_count: got %0d expected 1", retired_count); else n_pass++;
    // rs == rd in one retirement compares against the old value
    do_reset();
    load(64'd1, RPC, RPC + 32'd4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 32'hAAAA);
    tick();
    load(64'd2, RPC + 32'd4, RPC + 32'd8, 5'd9, 32'hAAAA, 5'd9, 32'hAAAA, 5'd9, 32'hBBBB);
    tick();
    load(64'd3, RPC + 32'd8, RPC + 32'd12, 5'd0, 32'd0, 5'd9, 32'hAAAA, 5'd0, 32'd0);
    tick();
    rvfi_valid = 1'b0;
    n_total++; if (error_code !== 4'd5 || retired_count !== 32'd2)
      $display("FAIL shadow_rsrd: got code %0d count %0d expected 5 and 2", error_code, retired_count); else n_pass++;
  endtask

  task automatic test_x0();
    do_reset();
    load(64'd1, RPC, RPC + 32'd4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'hFF);
    tick();
    n_total++; if (error_code !== 4'd3 || error_pc !== RPC || error_order !== 64'd1)
      $display("FAIL x0_code: got code %0d pc %h order %0d expected 3 %h 1", error_code, error_pc, error_order, RPC);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      load(64'(i + 2), 32'($urandom), 32'($urandom), 5'd1, 32'd0, 5'd2, 32'd0, 5'd0, 32'd9);
      tick();
    end
    rvfi_valid = 1'b0;
    n_total++; if (error !== 1'b1 || error_code !== 4'd3 || error_order !== 64'd1 || error_pc !== RPC ||
                   retired_count !== 32'd0 || state !== 2'd2)
      $display("FAIL x0_hold: got err %0b code %0d order %0d pc %h count %0d state %0d expected 1 3 1 %h 0 2",
               error, error_code, error_order, error_pc, retired_count, state, RPC);
    else n_pass++;
  endtask

  task automatic test_mem();
    do_reset();
    load(64'd1, RPC, RPC + 32'd4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    rvfi_mem_wmask = 4'b0011; rvfi_mem_addr = 32'h1001;
    tick();
    rvfi_valid = 1'b0;
`ifdef RVFI_MON_MEM_CHECK_EN
    n_total++; if (error !== 1'b1 || error_code !== 4'd7)
      $display("FAIL mem_misalign: got err %0b code %0d expected 1 7", error, error_code); else n_pass++;
`else
    n_total++; if (error !== 1'b0 || retired_count !== 32'd1 || state !== 2'd1)
      $display("FAIL mem_ignored: got err %0b count %0d state %0d expected 0 1 1", error, retired_count, state);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_priority();
    do_reset();
    load(64'd1, RPC, RPC + 32'd4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    load(64'd7, RPC + 32'd4, RPC + 32'd8, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++; if (error !== 1'b0 || state !== 2'd0 || retired_count !== 32'd0)
      $display("FAIL rstprio: got err %0b state %0d count %0d expected 0 0 0", error, state, retired_count);
    else n_pass++;
    load(64'd1, RPC, RPC + 32'd4, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    rvfi_valid = 1'b0;
    n_total++; if (error !== 1'b0 || state !== 2'd1 || retired_count !== 32'd1)
      $display("FAIL rstrestart: got err %0b state %0d count %0d expected 0 1 1", error, state, retired_count);
    else n_pass++;
  endtask

  // ---------------- randomized streams ----------------
  task automatic test_random();
    logic [31:0] pc, pcw, d1, d2, addr;
    logic [63:0] ord;
    logic [4:0]  r1, r2, rd;
    logic [3:0]  mk;
    int f, fail_hold;
    do_reset();
    fail_hold = 0;
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 199) == 0 || fail_hold > 3) begin
        fail_hold = 0;
        do_reset();
      end else if ($urandom_range(0, 4) == 0) begin
        rvfi_valid = 1'b0;
        rvfi_order = {$urandom, $urandom};
        tick();
      end else begin
        ord = (m_state == 0) ? 64'd1 : m_last_order + 64'd1;
        pc  = (m_state == 0) ? RPC : m_next_pc;
        pcw = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : pc + 32'd4;
        r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
        d1 = (r1 != 5'd0 && m_known[r1]) ? m_regs[r1] : $urandom;
        d2 = (r2 != 5'd0 && m_known[r2]) ? m_regs[r2] : $urandom;
        load(ord, pc, pcw, r1, d1, r2, d2, rd, (rd == 5'd0) ? 32'd0 : $urandom);
        case ($urandom_range(0, 3))
          0: mk = 4'd0;
          1: mk = 4'd1;
          2: mk = 4'd3;
          default: mk = 4'd15;
        endcase
        addr = $urandom & ((mk == 4'd15) ? 32'hFFFF_FFFC : (mk == 4'd3) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
        rvfi_mem_addr = addr;
        if ($urandom_range(0, 1) == 0) rvfi_mem_rmask = mk; else rvfi_mem_wmask = mk;
        f = $urandom_range(0, 59);
        case (f)
          0: rvfi_order = ord + 64'd2;
          1: rvfi_pc_rdata = pc ^ 32'h10;
          2: begin rvfi_rd_addr = 5'd0; rvfi_rd_wdata = $urandom | 32'd1; end
          3: rvfi_rs1_rdata = d1 ^ 32'h1;
          4: rvfi_rs2_rdata = d2 ^ 32'h100;
          5: begin rvfi_mem_rmask = 4'd1; rvfi_mem_wmask = 4'd15; end
          6: begin rvfi_mem_rmask = 4'd0; rvfi_mem_wmask = 4'd15; rvfi_mem_addr = addr | 32'd2; end
          default: ;
        endcase
        tick();
        if (m_state == 2) fail_hold++;
      end
      n_total++; if (state !== 2'(m_state)) $display("FAIL rnd_state it%0d: got %0d expected %0d", it, state, m_state); else n_pass++;
      n_total++; if (retired_count !== m_count) $display("FAIL rnd_count it%0d: got %0d expected %0d", it, retired_count, m_count); else n_pass++;
      n_total++; if (error !== m_err || error_code !== m_code)
        $display("FAIL rnd_err it%0d: got %0b/%0d expected %0b/%0d", it, error, error_code, m_err, m_code); else n_pass++;
      n_total++; if (error_order !== m_eorder || error_pc !== m_epc)
        $display("FAIL rnd_where it%0d: got %0h/%h expected %0h/%h", it, error_order, error_pc, m_eorder, m_epc); else n_pass++;
    end
    rvfi_valid = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_sequence();
    test_order_error();
    test_shadow();
    test_x0();
    test_mem();
    test_reset_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rvfi_monitor.md
RVFI_MONITOR -- requirements
Module: rvfi_monitor

Interface
REQ-001 Parameter RESET_PC, 32'h80000000, PC the first retired instruction SHALL report as rvfi_pc_rdata.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rvfi_valid  input  1  one retirement present this cycle.
REQ-005 rvfi_order  input  64  retirement sequence number.
REQ-006 rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata  input  32 each  instruction word, PC before retirement, PC after retirement.
REQ-007 rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  input  5 each  register indices.
REQ-008 rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  input  32 each  register read and write values.
REQ-009 rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata  input  32 each; rvfi_mem_rmask, rvfi_mem_wmask  input  4 each.
REQ-010 retired_count  output  32  count of retirements checked.
REQ-011 error  output  1  sticky; set on the first violation.
REQ-012 error_code  output  4  cause of the first violation.
REQ-013 error_order  output  64 and error_pc  output  32  rvfi_order and rvfi_pc_rdata of the offending retirement.
REQ-014 state  output  2  FSM state: 0 IDLE, 1 RUN, 2 FAIL.

Function
REQ-015 The FSM SHALL have three states: IDLE (no retirement seen yet), RUN, and FAIL; FAIL is terminal until reset.
REQ-016 In IDLE or RUN, each rvfi_valid=1 cycle SHALL be checked. The first failing check, in the priority order of REQ-018..REQ-024, SHALL be latched.
REQ-017 Expected order SHALL be 1 in IDLE and previous order+1 in RUN. Expected PC SHALL be RESET_PC in IDLE and the previous rvfi_pc_wdata in RUN.
REQ-018 Code 1: rvfi_order != expected order.
REQ-019 Code 2: rvfi_pc_rdata != expected PC.
REQ-020 Code 3: rvfi_rd_addr==0 and rvfi_rd_wdata!=0.
REQ-021 Code 4: rvfi_rs1_addr!=0, the shadow valid bit for rs1 is set, and rvfi_rs1_rdata != shadow[rs1]. Code 5: the same check applied to rs2.
REQ-022 Checks SHALL read the shadow register file before the same-cycle update, so rs==rd in one retirement compares against the old value.
REQ-023 Shadow update: on a passing retirement with rvfi_rd_addr!=0, shadow[rd] SHALL be set to rvfi_rd_wdata and its valid bit set. Entry 0 SHALL never be written.
REQ-024 Memory checks, codes 6 and 7, SHALL apply per Configuration.
REQ-025 Passing retirement: retired_count SHALL increment, wrapping at 2^32, and the state SHALL become RUN.
REQ-026 Failing retirement: on the next edge, error=1, error_code, error_order and error_pc SHALL be set and the state SHALL become FAIL. Shadow and retired_count SHALL NOT update for that retirement.
REQ-027 In FAIL, all inputs SHALL be ignored and all outputs held.
REQ-028 Output latency SHALL be one cycle from the rvfi_valid cycle. Cycles with rvfi_valid=0 SHALL change nothing.
REQ-029 Back-to-back valid cycles SHALL each be checked against the state committed by the previous cycle.

Reset
REQ-030 reset=1 SHALL force: state IDLE, retired_count 0, error 0, error_code 0, error_order 0, error_pc 0, and all shadow valid bits 0.
REQ-031 reset SHALL take priority over a simultaneous rvfi_valid; that retirement SHALL be discarded.
REQ-032 Reset mid-run SHALL restart expectation at order 1 and PC RESET_PC.

Configuration
REQ-033 With RVFI_MON_MEM_CHECK_EN defined, these checks SHALL be compiled in:
- Code 6: rmask and wmask are both nonzero, or either mask is not in {0,1,3,15}.
- Code 7: rvfi_mem_addr is misaligned for the nonzero mask (halfword: addr[0]!=0; word: addr[1:0]!=0).
REQ-034 Without RVFI_MON_MEM_CHECK_EN, codes 6 and 7 SHALL never be raised, and the memory inputs SHALL be unused.

Verification
REQ-035 Reset, then three retirements with order 1,2,3, pc 80000000->80000004->80000008 -> retired_count=3, error=0, state=1.
REQ-036 First retirement with order 2 -> one cycle later error=1, code=1, error_order=2, retired_count=0, state=2.
REQ-037 Retirement writes x5=0x1234, next retirement reads rs1=5 with rdata 0x1235 -> code=4, error_pc equals that retirement's pc.
REQ-038 rd=0 with rd_wdata=0xFF -> code 3. Further valid cycles -> outputs unchanged.
REQ-039 With macro defined: wmask=4'b0011, addr=0x1001 -> code 7. Without the macro: same stimulus -> no error.
REQ-040 Order violation asserted in the same cycle as reset -> error=0, state=0 after the edge.
